dmem_write_buffer: RTL and testbench
====================================

// Module: dmem_write_buffer
// PURPOSE
//  Posted-store buffer between the MIPS core's data port (we/addr/wdata) and data memory.
//  Stores retire in one cycle into a small FIFO; entries drain to memory under a ready handshake.
//  Loads that hit a buffered store are forwarded; same-word stores coalesce. Stall only when full.
// PARAMETERS
//  DEPTH  4   entries; power of two, 2..16
//  DW     32  data width (word)
//  AW     32  byte-address width; match/forward on addr[AW-1:2]; addr[1:0] ignored
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low
//  cpu_we     in   1          store request this cycle
//  cpu_re     in   1          load request this cycle (forward lookup)
//  cpu_addr   in   AW         store/load byte address
//  cpu_wdata  in   DW         store data
//  cpu_stall  out  1          store not accepted; core holds request
//  fwd_hit    out  1          load address matches a buffered entry
//  fwd_data   out  DW         youngest matching entry's data (0 when !fwd_hit)
//  mem_we     out  1          head entry valid (drain request)
//  mem_addr   out  AW         head entry address, addr[1:0]=0
//  mem_wdata  out  DW         head entry data
//  mem_ready  in   1          memory accepts head this cycle
//  count      out  clog2(DEPTH)+1  occupied entries
//  empty/full out  1          count==0 / count==DEPTH
// BEHAVIOUR
//  Reset (async, reset==0): all entries invalid, rd/wr ptr=0, count=0, mem_we=0, cpu_stall=0,
//   fwd_hit=0, fwd_data=0, mem_addr=0, mem_wdata=0; takes effect mid-drain, pending stores discarded.
//  Drain: mem_we=!empty; mem_addr/mem_wdata come straight from head regs (no comb path from cpu_*).
//   drain = mem_we & mem_ready -> head popped at the clock edge; mem_* stable while !mem_ready.
//  Store accept, priority order:
//   1 coalesce: cpu_we & addr matches a valid non-head entry, or the head when !drain -> overwrite
//     that entry's data in place; count unchanged.
//   2 enqueue: cpu_we & (!full | drain) & no coalesce -> write at wr_ptr, wr_ptr++ (mod DEPTH).
//   3 stall: cpu_we & full & !drain & no coalesce -> cpu_stall=1 (comb), nothing written.
//  Head match while drain: no coalesce; new entry is enqueued (memory sees both writes, in order).
//  Count: +1 enqueue, -1 drain, unchanged on both or neither; never exceeds DEPTH or wraps below 0.
//  Forward: combinational, same cycle: cpu_re & match -> fwd_hit=1, fwd_data=youngest match.
//   The same-cycle store is not visible to forwarding (store-then-load next cycle hits).
//   Coalescing keeps at most one valid entry per word, so youngest == unique match.
//  cpu_we & cpu_re together: forward lookup uses pre-store contents.
//  Pointers wrap mod DEPTH; full distinguished from empty by count, not pointer compare.
//  Latency: accepted store visible on mem_* >=1 cycle later (next edge when buffer was empty).
// STRUCTURE
//  mips_defs.vh: WORD_W=32, word-address slice macro, clog2 function; shared with the core and dmem.
//  Sub-module wb_match (DEPTH-way address compare + youngest-hit one-hot/priority -> index, hit).
//  Instantiated twice: store-coalesce port and load-forward port. Top holds regs, ptrs, count.
// TESTING
//  T1 reset low mid-run with 3 entries, mem_ready=0 -> count=0, mem_we=0 immediately (async).
//  T2 store 7@84, mem_ready=1 -> next cycle mem_we=1, mem_addr=84, mem_wdata=7; popped, empty=1.
//  T3 mem_ready=0; stores to 0,4,8,12 -> full=1; 5th store@16 -> cpu_stall=1; mem_ready=1
//     same cycle -> stall=0, 16 enqueued; count stays 4; drain order 0,4,8,12,16.
//  T4 mem_ready=0; 5@80 then 9@80 -> count=1, mem_wdata=9; store 3@82 -> coalesces (word 80), data 3.
//  T5 store 0xAB@40, next cycle load@40 -> fwd_hit=1, fwd_data=0xAB; load@44 -> fwd_hit=0, data 0.
//  T6 head=1@80 draining (mem_ready=1) & store 2@80 same cycle -> mem sees 1 then 2; count 1.

Source files
------------

// File: rtl/dmem_write_buffer_pkg.sv
// Shared definitions for the data-memory posted-store buffer.
package dmem_write_buffer_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_DW    = 32;
    localparam int WB_AW    = 32;

    // What happens to a store presented by the core this cycle
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COALESCE,
        ST_ENQUEUE,
        ST_STALL
    } st_act_e;

    // Width of the occupancy counter: must hold 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dmem_write_buffer_if.sv
// Core-side and memory-side signals of the posted-store buffer.
interface dmem_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
);
    import dmem_write_buffer_pkg::*;

    localparam int CW = cnt_w(DEPTH);

    logic          cpu_we;
    logic          cpu_re;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    // Buffer side
    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_ready,
        output cpu_stall, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata,
               count, empty, full
    );

    // Core + memory side
    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_ready,
        input  cpu_stall, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata,
               count, empty, full
    );

endinterface

// File: rtl/dmem_write_buffer_match.sv
// DEPTH-way word-address compare; returns the youngest matching entry.
module dmem_write_buffer_match #(
    parameter int DEPTH = 4,
    parameter int TW    = 30,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][TW-1:0] tags,
    input  logic [TW-1:0]            key,
    input  logic [PW-1:0]            rd_ptr,
    output logic                     hit,
    output logic [PW-1:0]            idx
);

    logic [PW-1:0] p;

    // Walk oldest->youngest from the head; the last hit wins, so idx is the youngest match
    always_comb begin
        hit = 1'b0;
        idx = '0;
        p   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            p = rd_ptr + PW'(k);
            if (valid[p] && tags[p] == key) begin
                hit = 1'b1;
                idx = p;
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer between the core data port and data memory.
// Stores retire into a small FIFO, drain under mem_ready, coalesce per word,
// and loads hitting a buffered word are forwarded combinationally.
module dmem_write_buffer
    import dmem_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic               clk,
    input  logic               reset,
    dmem_write_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = AW - 2;
    localparam int CW = cnt_w(DEPTH);

    logic [DEPTH-1:0]         valid;
    logic [DEPTH-1:0][TW-1:0] tags;
    logic [DEPTH-1:0][DW-1:0] data;
    logic [PW-1:0]            rd_ptr, wr_ptr;
    logic [CW-1:0]            count_q;

    logic [TW-1:0]    key;
    logic             drain;
    logic [DEPTH-1:0] head_mask;
    logic             st_hit, ld_hit;
    logic [PW-1:0]    st_idx, ld_idx;
    st_act_e          act;
    logic             unused_low;

    // Byte offset within the word never takes part in matching
    assign unused_low = ^bus.cpu_addr[1:0];
    assign key        = bus.cpu_addr[AW-1:2];

    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == CW'(DEPTH));
    assign bus.count     = count_q;
    assign bus.mem_we    = !bus.empty;
    assign bus.mem_addr  = {tags[rd_ptr], 2'b00};
    assign bus.mem_wdata = data[rd_ptr];

    assign drain = bus.mem_we & bus.mem_ready;

    // A head leaving this edge must not absorb a store: memory has to see both writes
    assign head_mask = drain ? (DEPTH'(1) << rd_ptr) : '0;

    dmem_write_buffer_match #(.DEPTH(DEPTH), .TW(TW), .PW(PW)) u_st_match (
        .valid (valid & ~head_mask),
        .tags  (tags),
        .key   (key),
        .rd_ptr(rd_ptr),
        .hit   (st_hit),
        .idx   (st_idx)
    );

    dmem_write_buffer_match #(.DEPTH(DEPTH), .TW(TW), .PW(PW)) u_ld_match (
        .valid (valid),
        .tags  (tags),
        .key   (key),
        .rd_ptr(rd_ptr),
        .hit   (ld_hit),
        .idx   (ld_idx)
    );

    // Store decision: coalesce beats enqueue; stall only when nothing can take it
    always_comb begin
        act = ST_IDLE;
        if (bus.cpu_we) begin
            if (st_hit)                  act = ST_COALESCE;
            else if (!bus.full || drain) act = ST_ENQUEUE;
            else                         act = ST_STALL;
        end
    end

    assign bus.cpu_stall = (act == ST_STALL);
    assign bus.fwd_hit   = bus.cpu_re & ld_hit;
    assign bus.fwd_data  = bus.fwd_hit ? data[ld_idx] : '0;

    // Entry storage, pointers and occupancy; pop is applied before push so a
    // full buffer can refill the slot being drained in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid   <= '0;
            tags    <= '0;
            data    <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (drain) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            case (act)
                ST_COALESCE: data[st_idx] <= bus.cpu_wdata;
                ST_ENQUEUE: begin
                    valid[wr_ptr] <= 1'b1;
                    tags[wr_ptr]  <= key;
                    data[wr_ptr]  <= bus.cpu_wdata;
                    wr_ptr        <= wr_ptr + PW'(1);
                end
                default: ;
            endcase
            case ({act == ST_ENQUEUE, drain})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: queue-based reference model plus directed scenarios.
module tb_dmem_write_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dmem_write_buffer_if #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) bus ();

    dmem_write_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];

    int total = 0;
    int bad   = 0;

    // Decisions for the coming edge, worked out from the model
    bit          d_act   = 1'b0;
    bit          d_coal  = 1'b0;
    int          d_ci    = 0;
    bit          d_drain = 1'b0;
    bit          d_enq   = 1'b0;
    logic [29:0] d_w     = '0;
    logic [31:0] d_d     = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Compare all outputs against the model for the current inputs
    task automatic model_check();
        int          n;
        bit          mwe, drn, fh, enq, stall;
        logic [31:0] fd;
        logic [29:0] w;
        int          ci;
        n   = q.size();
        mwe = (n != 0);
        drn = mwe && bus.mem_ready;
        w   = bus.cpu_addr[31:2];
        fh  = 1'b0;
        fd  = '0;
        if (bus.cpu_re)
            for (int i = n - 1; i >= 0; i--)
                if (!fh && q[i].w == w) begin fh = 1'b1; fd = q[i].d; end
        ci = -1;
        if (bus.cpu_we)
            for (int i = 0; i < n; i++)
                if (q[i].w == w && !(i == 0 && drn)) ci = i;
        enq   = bus.cpu_we && ci < 0 && (n < DEPTH || drn);
        stall = bus.cpu_we && ci < 0 && !enq;

        chk("count",     bus.count, n);
        chk("empty",     bus.empty, n == 0);
        chk("full",      bus.full,  n == DEPTH);
        chk("mem_we",    bus.mem_we, mwe);
        chk("cpu_stall", bus.cpu_stall, stall);
        chk("fwd_hit",   bus.fwd_hit, fh);
        chk("fwd_data",  bus.fwd_data, fd);
        if (mwe) begin
            chk("mem_addr",  bus.mem_addr, {q[0].w, 2'b00});
            chk("mem_wdata", bus.mem_wdata, q[0].d);
        end

        d_coal  = (ci >= 0);
        d_ci    = ci;
        d_drain = drn;
        d_enq   = enq;
        d_w     = w;
        d_d     = bus.cpu_wdata;
        d_act   = 1'b1;
    endtask

    // Apply this cycle's decisions to the model at the clock edge
    always @(posedge clk) begin
        if (reset && d_act) begin
            if (d_coal)  q[d_ci].d = d_d;
            if (d_drain) void'(q.pop_front());
            if (d_enq)   q.push_back('{w: d_w, d: d_d});
            d_act = 1'b0;
        end
    end

    task automatic drive(input bit we, input bit re, input logic [31:0] a,
                         input logic [31:0] wd, input bit rdy);
        @(negedge clk);
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.mem_ready = rdy;
        #1;
        model_check();
    endtask

    // Assert reset mid-cycle and check that it bites before any clock edge
    task automatic do_reset();
        @(negedge clk);
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        reset = 1'b0;
        d_act = 1'b0;
        #1;
        chk("rst_count",   bus.count, 0);
        chk("rst_mem_we",  bus.mem_we, 0);
        chk("rst_stall",   bus.cpu_stall, 0);
        chk("rst_fwd_hit", bus.fwd_hit, 0);
        chk("rst_fwd_dat", bus.fwd_data, 0);
        chk("rst_maddr",   bus.mem_addr, 0);
        chk("rst_mwdata",  bus.mem_wdata, 0);
        chk("rst_empty",   bus.empty, 1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int exp_a[4];
        bit rdy;
        logic [31:0] a;
        exp_a = '{4, 8, 12, 16};
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ready = 1'b0;

        do_reset();

        // T1: three stores held by memory, then async reset
        drive(1, 0, 32'h10, 32'h11, 0);
        drive(1, 0, 32'h14, 32'h22, 0);
        drive(1, 0, 32'h18, 32'h33, 0);
        drive(0, 0, 0, 0, 0);
        chk("t1_count_pre", bus.count, 3);
        do_reset();

        // T2: single store drains the following cycle
        drive(1, 0, 84, 7, 1);
        chk("t2_mem_we0", bus.mem_we, 0);
        drive(0, 0, 0, 0, 1);
        chk("t2_mem_we",  bus.mem_we, 1);
        chk("t2_addr",    bus.mem_addr, 84);
        chk("t2_data",    bus.mem_wdata, 7);
        drive(0, 0, 0, 0, 1);
        chk("t2_empty",   bus.empty, 1);

        // T3: fill, stall, release by drain in the same cycle
        drive(1, 0, 0,  32'h100, 0);
        drive(1, 0, 4,  32'h104, 0);
        drive(1, 0, 8,  32'h108, 0);
        drive(1, 0, 12, 32'h10c, 0);
        drive(1, 0, 16, 32'h110, 0);
        chk("t3_full",   bus.full, 1);
        chk("t3_stall",  bus.cpu_stall, 1);
        drive(1, 0, 16, 32'h110, 1);
        chk("t3_nostall", bus.cpu_stall, 0);
        chk("t3_head0",   bus.mem_addr, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            chk("t3_count", bus.count, 4 - i);
            chk("t3_order", bus.mem_addr, exp_a[i]);
        end
        drive(0, 0, 0, 0, 0);
        chk("t3_empty", bus.empty, 1);

        // T4: same-word coalescing, byte offset ignored
        drive(1, 0, 80, 5, 0);
        drive(1, 0, 80, 9, 0);
        drive(0, 0, 0, 0, 0);
        chk("t4_count", bus.count, 1);
        chk("t4_data9", bus.mem_wdata, 9);
        drive(1, 0, 82, 3, 0);
        drive(0, 0, 0, 0, 0);
        chk("t4_count2", bus.count, 1);
        chk("t4_data3",  bus.mem_wdata, 3);
        chk("t4_addr",   bus.mem_addr, 80);

        // T5: store then load forwards; other word misses
        drive(1, 0, 40, 32'hAB, 0);
        drive(0, 1, 40, 0, 0);
        chk("t5_hit",   bus.fwd_hit, 1);
        chk("t5_data",  bus.fwd_data, 32'hAB);
        drive(0, 1, 44, 0, 0);
        chk("t5_miss",  bus.fwd_hit, 0);
        chk("t5_zero",  bus.fwd_data, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1);
        chk("t5_drained", bus.empty, 1);

        // T6: store to the word that is draining becomes a new entry
        drive(1, 0, 80, 1, 0);
        drive(1, 0, 80, 2, 1);
        chk("t6_head1", bus.mem_wdata, 1);
        drive(0, 0, 0, 0, 0);
        chk("t6_count", bus.count, 1);
        chk("t6_head2", bus.mem_wdata, 2);
        chk("t6_addr",  bus.mem_addr, 80);
        drive(0, 0, 0, 0, 1);

        // Randomized traffic over a small set of words to provoke hits and fills
        for (int c = 0; c < 3000; c++) begin
            rdy = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            a   = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, a, $urandom, rdy);
            if (c == 2000) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
